// File: rtl/seq_pattern_detector_if.sv
// Port bundle for seq_pattern_detector: configuration fields, the qualified
// serial input, and the match outputs.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LW     = $clog2(MAX_LEN + 1)
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cfg_moore;
  logic               in_valid;
  logic               A;
  logic               Y;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore, in_valid, A,
    input  Y, match_count
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore, in_valid, A,
    output Y, match_count
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap / non-overlap
// matching, Mealy or Moore output timing and a saturating match counter.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input logic             clk,
  input logic             reset,
  seq_pattern_detector_if.slave bus
);

  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      len;
  logic [LW-1:0]      fill;
  logic               ovl;
  logic               moore;
  logic               y_q;
  logic [CNT_W-1:0]   match_count;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LW:0]        fill_p1;
  logic               hit;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0) return LW'(1);
    if (l > LW'(MAX_LEN)) return LW'(MAX_LEN);
    return l;
  endfunction

  // Match window: the newest bit sits at position 0, pattern bit 0 is the last received.
  always_comb begin
    win     = {hist[MAX_LEN-2:0], bus.A};
    mask    = len_mask(len);
    fill_p1 = {1'b0, fill} + (LW+1)'(1);
    hit     = bus.in_valid && !bus.cfg_load &&
              (fill_p1 >= {1'b0, len}) &&
              ((win & mask) == (pat & mask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat         <= MAX_LEN'(3'b111);
      len         <= LW'(3);
      ovl         <= 1'b1;
      moore       <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      y_q         <= 1'b0;
      match_count <= '0;
    end else if (bus.cfg_load) begin
      pat         <= bus.cfg_pattern;
      len         <= clamp_len(bus.cfg_len);
      ovl         <= bus.cfg_overlap;
      moore       <= bus.cfg_moore;
      hist        <= '0;
      fill        <= '0;
      y_q         <= 1'b0;
      match_count <= '0;
    end else begin
      y_q <= hit;
      if (bus.in_valid) begin
        hist <= win;
        // Non-overlapping mode restarts the fill so no bit is shared between matches.
        if (hit && !ovl)
          fill <= '0;
        else if (fill != LW'(MAX_LEN))
          fill <= fill + LW'(1);
        if (hit && (match_count != '1))
          match_count <= match_count + CNT_W'(1);
      end
    end
  end

  assign bus.Y           = moore ? y_q : hit;
  assign bus.match_count = match_count;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomized and directed bench for seq_pattern_detector against a bit-queue
// reference model; a second instance with a 2-bit counter tracks saturation.
module tb_seq_pattern_detector;
  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus ();
  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus2 ();

  assign bus2.cfg_load    = bus.cfg_load;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_len     = bus.cfg_len;
  assign bus2.cfg_overlap = bus.cfg_overlap;
  assign bus2.cfg_moore   = bus.cfg_moore;
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.A           = bus.A;

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Configuration presented on the next step (only latched when that step loads).
  logic [MAX_LEN-1:0] c_pat;
  logic [LW-1:0]      c_len;
  logic               c_ovl, c_moore;

  // Reference model: accepted bits since the last restart, oldest first.
  logic [MAX_LEN-1:0] pat_m;
  int                 len_m;
  bit                 ovl_m, moore_m, yq_m;
  bit                 q[$];
  int                 cnt_m, cnt2_m;

  task automatic model_reset();
    pat_m = MAX_LEN'(3'b111); len_m = 3; ovl_m = 1'b1; moore_m = 1'b0;
    q.delete(); cnt_m = 0; cnt2_m = 0; yq_m = 1'b0;
  endtask

  function automatic bit model_hit(bit iv, bit a);
    if (!iv) return 1'b0;
    if (q.size() < len_m - 1) return 1'b0;
    for (int k = 0; k < len_m - 1; k++)
      if (q[q.size() - (len_m - 1) + k] != pat_m[len_m-1-k]) return 1'b0;
    return a == pat_m[0];
  endfunction

  task automatic step(input bit ld, input bit iv, input bit a, input bit rs, output bit y_obs);
    bit h, exp_y;
    @(negedge clk);
    reset           = rs;
    bus.cfg_load    = ld;
    bus.cfg_pattern = c_pat;
    bus.cfg_len     = c_len;
    bus.cfg_overlap = c_ovl;
    bus.cfg_moore   = c_moore;
    bus.in_valid    = iv;
    bus.A           = a;
    #1;
    h     = !ld && model_hit(iv, a);
    exp_y = moore_m ? yq_m : h;
    y_obs = bus.Y;
    chk("Y", bus.Y, exp_y);
    chk("Y_sat", bus2.Y, exp_y);
    chk("count", bus.match_count, cnt_m);
    chk("count_sat", bus2.match_count, cnt2_m);
    if (rs) model_reset();
    else if (ld) begin
      pat_m   = c_pat;
      len_m   = (c_len == 0) ? 1 : ((int'(c_len) > MAX_LEN) ? MAX_LEN : int'(c_len));
      ovl_m   = c_ovl;
      moore_m = c_moore;
      q.delete(); cnt_m = 0; cnt2_m = 0; yq_m = 1'b0;
    end else begin
      yq_m = h;
      if (iv) begin
        q.push_back(a);
        if (h && !ovl_m) q.delete();
        else if (q.size() > MAX_LEN) void'(q.pop_front());
        if (h) begin
          if (cnt_m < 255) cnt_m++;
          if (cnt2_m < 3) cnt2_m++;
        end
      end
    end
  endtask

  // Sends n valid bits, first bit = bits[n-1]; ys collects Y with the first sample as MSB.
  task automatic send(input int n, input logic [31:0] bits, output logic [31:0] ys);
    bit y;
    ys = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, bits[n-1-i], 1'b0, y);
      ys = {ys[30:0], y};
    end
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input bit m);
    c_pat = p; c_len = LW'(l); c_ovl = o; c_moore = m;
  endtask

  initial begin
    logic [31:0] ys;
    bit y;
    reset = 1'b1;
    bus.cfg_load = 1'b0; bus.in_valid = 1'b0; bus.A = 1'b0;
    set_cfg(8'b111, 3, 1'b1, 1'b0);
    bus.cfg_pattern = c_pat; bus.cfg_len = c_len;
    bus.cfg_overlap = c_ovl; bus.cfg_moore = c_moore;
    repeat (3) @(posedge clk);
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, y);
    chk("rst_Y", bus.Y, 0);
    chk("rst_count", bus.match_count, 0);

    // Default 111, overlapping, Mealy
    send(8, 8'b11110111, ys);
    chk("t111_Y", ys[7:0], 8'b00110001);
    step(1'b0, 1'b0, 1'b0, 1'b0, y);
    chk("t111_count", bus.match_count, 3);

    // Non-overlapping 111
    set_cfg(8'b111, 3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, y);
    send(6, 6'b111111, ys);
    chk("nonovl_Y", ys[5:0], 6'b001001);
    step(1'b0, 1'b0, 1'b0, 1'b0, y);
    chk("nonovl_count", bus.match_count, 2);

    // Programmed 1011, overlapping then non-overlapping
    set_cfg(8'b1011, 4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, y);
    send(7, 7'b1011011, ys);
    chk("p1011_ovl_Y", ys[6:0], 7'b0001001);
    set_cfg(8'b1011, 4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, y);
    send(7, 7'b1011011, ys);
    chk("p1011_nonovl_Y", ys[6:0], 7'b0001000);

    // Moore output with idle gaps inside the match
    set_cfg(8'b101, 3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, y);
    ys = '0;
    step(1'b0, 1'b1, 1'b1, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b0, 1'b0, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b1, 1'b0, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b0, 1'b0, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b0, 1'b0, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b1, 1'b1, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b0, 1'b0, 1'b0, y); ys = {ys[30:0], y};
    step(1'b0, 1'b0, 1'b0, 1'b0, y); ys = {ys[30:0], y};
    chk("moore_gap_Y", ys[7:0], 8'b00000010);

    // Saturation of the 2-bit counter
    set_cfg(8'b111, 3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, y);
    send(8, 8'hFF, ys);
    step(1'b0, 1'b0, 1'b0, 1'b0, y);
    chk("sat_count8", bus.match_count, 6);
    chk("sat_count2", bus2.match_count, 3);

    // Load mid-stream discards the sample and the partial history
    send(2, 2'b11, ys);
    step(1'b1, 1'b1, 1'b1, 1'b0, y);
    chk("load_cycle_Y", y, 0);
    send(3, 3'b111, ys);
    chk("after_load_Y", ys[2:0], 3'b001);

    // Reset mid-stream restores the 111 defaults and clears the history
    set_cfg(8'b0101, 4, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, y);
    send(6, 6'b101011, ys);
    step(1'b0, 1'b0, 1'b0, 1'b1, y);
    step(1'b0, 1'b0, 1'b0, 1'b1, y);
    chk("rst_mid_Y", bus.Y, 0);
    chk("rst_mid_count", bus.match_count, 0);
    send(3, 3'b111, ys);
    chk("rst_mid_default_Y", ys[2:0], 3'b001);

    // Randomized traffic including loads (with out-of-range lengths) and resets
    for (int i = 0; i < 3000; i++) begin
      bit rs, ld, iv, a;
      rs = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 39) == 0);
      if (ld) begin
        c_pat   = MAX_LEN'($urandom);
        c_len   = LW'($urandom_range(0, 15));
        c_ovl   = 1'($urandom_range(0, 1));
        c_moore = 1'($urandom_range(0, 1));
      end
      iv = ($urandom_range(0, 3) != 0);
      a  = 1'($urandom_range(0, 1));
      step(ld, iv, a, rs, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
